// File: rtl/mac_seq.sv
// mac_seq: burst multiply-accumulate stage.
// Takes a start/len request, accepts len (x,y) operand pairs over a valid/ready
// stream, then presents sum(x*y) on a valid/ready result port.
// Optional: define MAC_SAT_EN to saturate the accumulator and report ovf;
// without it the sum wraps modulo 2^ACC_W and ovf is tied low.
module mac_seq #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4,
    parameter int ACC_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic               busy,
    output logic               err,
    output logic               ovf
);

    typedef enum logic [3:0] {
        IDLE   = 4'h0,
        ACCUM  = 4'h1,
        RESULT = 4'h2
    } state_t;

    // Product is computed at least 2*WIDTH wide so it is never truncated
    // before the explicit resize to ACC_W.
    localparam int PW = (ACC_W > 2*WIDTH) ? ACC_W : 2*WIDTH;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;
    logic [PW-1:0]      prod_w;
    logic [ACC_W-1:0]   prod;
`ifdef MAC_SAT_EN
    logic [ACC_W:0]     sum;
`else
    logic [ACC_W-1:0]   sum;
`endif

    // Full-precision product resized to accumulator width, then summed
    always_comb begin
        prod_w = PW'(in_x) * PW'(in_y);
        prod   = prod_w[ACC_W-1:0];
`ifdef MAC_SAT_EN
        sum    = {1'b0, acc_q} + {1'b0, prod};
`else
        sum    = acc_q + prod;
`endif
    end

    // Next-state and datapath updates; unused state codes fall back to IDLE
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_acc_d = out_acc_q;
        rem_d     = rem_q;
        err_d     = 1'b0;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = ACCUM;
                        rem_d   = len;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
`ifdef MAC_SAT_EN
                    // Once clamped, any further add carries again, so acc stays saturated
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
`else
                    acc_d = sum;
`endif
                    rem_d = rem_q - COUNT_W'(1);
                    if (rem_q == COUNT_W'(1)) begin
                        state_d   = RESULT;
                        // Result register only changes when a burst completes
                        out_acc_d = acc_d;
                    end
                end
            end
            RESULT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            out_acc_q <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_acc_q <= out_acc_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign out_acc   = out_acc_q;
    assign err       = err_q;
`ifdef MAC_SAT_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule
